// File: rtl/coin_sched_pkg.sv
// Shared types and constants for the coin spawn scheduler: lane states,
// LFSR seed/taps and the score/miss counter widths.
package coin_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      TRAVEL,
      WINDOW,
      COOLDOWN
   } lane_state_t;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   // x^8 + x^6 + x^5 + x^4 + 1, feedback from bits 7,5,4,3
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   localparam int SCORE_W = 16;
   localparam int MISS_W  = 8;

   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {cur[6:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/coin_lane_fsm.sv
// One coin lane: travel, catch window and cooldown sequencing. The catch and
// miss flags are single-cycle strobes that the top level registers.
module coin_lane_fsm
   import coin_sched_pkg::*;
#(
   parameter int WINDOW_FRAMES   = 12,
   parameter int COOLDOWN_FRAMES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic grant,
   input  logic tick,
   input  logic in_position,
   input  logic player_hit,
   input  logic abort,
   output logic active,
   output logic catch,
   output logic miss,
   output logic idle
);

   localparam int T_MAX = (WINDOW_FRAMES > COOLDOWN_FRAMES) ? WINDOW_FRAMES : COOLDOWN_FRAMES;
   localparam int T_W   = $clog2(T_MAX + 1);

   lane_state_t     state_reg, state_next;
   logic [T_W-1:0]  cnt_reg, cnt_next;
   logic            active_reg, active_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         active_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         active_reg <= active_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      catch      = 1'b0;
      miss       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (grant) state_next = TRAVEL;
         end
         TRAVEL: begin
            if (abort) begin
               state_next = COOLDOWN;
               cnt_next   = T_W'(COOLDOWN_FRAMES);
            end else if (tick && in_position) begin
               state_next = WINDOW;
               cnt_next   = T_W'(WINDOW_FRAMES);
            end
         end
         WINDOW: begin
            // abort outranks a hit so a disabled game never scores
            if (abort) begin
               state_next = COOLDOWN;
               cnt_next   = T_W'(COOLDOWN_FRAMES);
            end else if (player_hit) begin
               catch      = 1'b1;
               state_next = COOLDOWN;
               cnt_next   = T_W'(COOLDOWN_FRAMES);
            end else if (tick) begin
               if (cnt_reg == T_W'(1)) begin
                  miss       = 1'b1;
                  state_next = COOLDOWN;
                  cnt_next   = T_W'(COOLDOWN_FRAMES);
               end else begin
                  cnt_next = cnt_reg - T_W'(1);
               end
            end
         end
         COOLDOWN: begin
            if (tick) begin
               if (cnt_reg <= T_W'(1)) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg - T_W'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
      active_next = (state_next == TRAVEL) || (state_next == WINDOW);
   end

   assign active = active_reg;
   assign idle   = (state_reg == IDLE);

endmodule

// File: rtl/coin_spawn_scheduler.sv
// Frame-rate coin scheduler: v-sync tick detection, LFSR lane choice, spawn
// arbitration across the lane FSMs and catch/miss accounting.
module coin_spawn_scheduler
   import coin_sched_pkg::*;
#(
   parameter int N_LANES         = 3,
   parameter int SPAWN_FRAMES    = 45,
   parameter int WINDOW_FRAMES   = 12,
   parameter int COOLDOWN_FRAMES = 2,
   parameter int MAX_LIVE        = 2,
   parameter int MAX_MISSES      = 5
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_v_sync,
   input  logic               i_enable,
   input  logic [N_LANES-1:0] i_in_position,
   input  logic [N_LANES-1:0] i_player_hit,
   output logic [N_LANES-1:0] o_active,
   output logic [SCORE_W-1:0] o_score,
   output logic [MISS_W-1:0]  o_misses,
   output logic               o_catch_pulse,
   output logic               o_miss_pulse,
   output logic               o_game_over
);

   localparam int SPAWN_W = ($clog2(SPAWN_FRAMES) > 6) ? $clog2(SPAWN_FRAMES) : 6;
   localparam int LANE_W  = (N_LANES > 1) ? $clog2(N_LANES) : 1;

   logic               vs_meta_reg, vs_sync_reg, vs_prev_reg, tick_reg;
   logic [7:0]         lfsr_reg;
   logic [SPAWN_W-1:0] spawn_cnt_reg, spawn_cnt_next;
   logic [SCORE_W-1:0] score_reg, score_next;
   logic [MISS_W-1:0]  misses_reg, misses_next;
   logic               catch_pulse_reg, miss_pulse_reg, game_over_reg;
   logic [N_LANES-1:0] grant, lane_active, lane_catch, lane_miss, lane_idle;
   logic               spawn_pending, run, granted;

   assign spawn_pending = (spawn_cnt_reg == SPAWN_W'(SPAWN_FRAMES - 1));
   assign run           = i_enable && !game_over_reg;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vs_meta_reg     <= 1'b0;
         vs_sync_reg     <= 1'b0;
         vs_prev_reg     <= 1'b0;
         tick_reg        <= 1'b0;
         lfsr_reg        <= LFSR_SEED;
         spawn_cnt_reg   <= '0;
         score_reg       <= '0;
         misses_reg      <= '0;
         catch_pulse_reg <= 1'b0;
         miss_pulse_reg  <= 1'b0;
         game_over_reg   <= 1'b0;
      end else begin
         vs_meta_reg     <= i_v_sync;
         vs_sync_reg     <= vs_meta_reg;
         vs_prev_reg     <= vs_sync_reg;
         tick_reg        <= vs_sync_reg & ~vs_prev_reg;
         if (tick_reg) lfsr_reg <= lfsr_next(lfsr_reg);
         spawn_cnt_reg   <= spawn_cnt_next;
         score_reg       <= score_next;
         misses_reg      <= misses_next;
         catch_pulse_reg <= |lane_catch;
         miss_pulse_reg  <= |lane_miss;
         game_over_reg   <= game_over_reg | (misses_next == MISS_W'(MAX_MISSES));
      end
   end

   // Rotating search for the first idle lane starting at the LFSR's choice
   always_comb begin
      int pref;
      int idx;
      grant   = '0;
      granted = 1'b0;
      idx     = 0;
      pref    = int'(lfsr_reg) % N_LANES;
      if (tick_reg && run && spawn_pending && ($countones(lane_active) < MAX_LIVE)) begin
         for (int k = 0; k < N_LANES; k++) begin
            idx = (pref + k) % N_LANES;
            if (!granted && lane_idle[LANE_W'(idx)]) begin
               grant[LANE_W'(idx)] = 1'b1;
               granted             = 1'b1;
            end
         end
      end
      spawn_cnt_next = spawn_cnt_reg;
      if (tick_reg && run) begin
         if (granted)             spawn_cnt_next = '0;
         else if (!spawn_pending) spawn_cnt_next = spawn_cnt_reg + SPAWN_W'(1);
      end
   end

   always_comb begin
      logic [SCORE_W:0] score_sum;
      logic [MISS_W:0]  miss_sum;
      score_sum   = {1'b0, score_reg} + (SCORE_W + 1)'($countones(lane_catch));
      miss_sum    = {1'b0, misses_reg} + (MISS_W + 1)'($countones(lane_miss));
      score_next  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
      misses_next = (miss_sum >= (MISS_W + 1)'(MAX_MISSES)) ? MISS_W'(MAX_MISSES)
                                                            : miss_sum[MISS_W-1:0];
   end

   generate
      for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
         coin_lane_fsm #(
            .WINDOW_FRAMES   (WINDOW_FRAMES),
            .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
         ) u_lane (
            .clk         (i_clk),
            .rst_n       (i_rst_n),
            .grant       (grant[gi]),
            .tick        (tick_reg),
            .in_position (i_in_position[gi]),
            .player_hit  (i_player_hit[gi]),
            .abort       (!i_enable),
            .active      (lane_active[gi]),
            .catch       (lane_catch[gi]),
            .miss        (lane_miss[gi]),
            .idle        (lane_idle[gi])
         );
      end
   endgenerate

   assign o_active      = lane_active;
   assign o_score       = score_reg;
   assign o_misses      = misses_reg;
   assign o_catch_pulse = catch_pulse_reg;
   assign o_miss_pulse  = miss_pulse_reg;
   assign o_game_over   = game_over_reg;

endmodule

// File: tb/tb_coin_spawn_scheduler.sv
// Directed bench for coin_spawn_scheduler: spawn timing and lane choice,
// catch/miss scoring, live-lane cap, game over, abort and async reset.
module tb_coin_spawn_scheduler;

   localparam int N = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          v_sync = 1'b0;
   logic          enable = 1'b0;
   logic [N-1:0]  in_position = '0;
   logic [N-1:0]  player_hit = '0;
   logic [N-1:0]  active;
   logic [15:0]   score;
   logic [7:0]    misses;
   logic          catch_pulse, miss_pulse, game_over;

   int            n_checks = 0;
   int            n_fail = 0;
   int            tick_no = 0;
   logic [7:0]    exp_lfsr = 8'hA5;

   coin_spawn_scheduler #(
      .N_LANES(N), .SPAWN_FRAMES(45), .WINDOW_FRAMES(12),
      .COOLDOWN_FRAMES(2), .MAX_LIVE(2), .MAX_MISSES(5)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_v_sync      (v_sync),
      .i_enable      (enable),
      .i_in_position (in_position),
      .i_player_hit  (player_hit),
      .o_active      (active),
      .o_score       (score),
      .o_misses      (misses),
      .o_catch_pulse (catch_pulse),
      .o_miss_pulse  (miss_pulse),
      .o_game_over   (game_over)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
         $display("tick %0d check %s observed=%0h expected=%0h ok", tick_no, tag, obs, exp);
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference LFSR: shift left, feedback from the x^8,x^6,x^5,x^4 taps
   function automatic logic [7:0] model_lfsr(input logic [7:0] v);
      logic fb;
      fb = v[7] ^ v[5] ^ v[4] ^ v[3];
      return {v[6:0], fb};
   endfunction

   function automatic int lane_of(input logic [7:0] v);
      return int'(v) % N;
   endfunction

   function automatic logic [N-1:0] lane_mask(input int l);
      return N'(1) << l;
   endfunction

   task automatic tick_rise();
      v_sync = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic tick_edge();
      @(negedge clk);
      exp_lfsr = model_lfsr(exp_lfsr);
      tick_no++;
   endtask

   task automatic frame_end();
      v_sync = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic frame();
      tick_rise();
      tick_edge();
      frame_end();
   endtask

   task automatic hit_pulse(input logic [N-1:0] m);
      player_hit = m;
      @(negedge clk);
      player_hit = '0;
   endtask

   task automatic wait_grant(output logic [N-1:0] m);
      for (int i = 0; i < 50; i++) begin
         frame();
         if (active != '0) break;
      end
      m = active;
      check("grant_seen", 32'(active != '0), 32'(1));
   endtask

   initial begin
      int lane_a, lane_b, c1, c2, l3, p, over_cap;
      logic [N-1:0] m, seen;

      repeat (3) @(negedge clk);
      check("rst_active", 32'(active), 32'(0));
      check("rst_score", 32'(score), 32'(0));
      check("rst_misses", 32'(misses), 32'(0));
      check("rst_pulses", 32'({catch_pulse, miss_pulse}), 32'(0));
      check("rst_game_over", 32'(game_over), 32'(0));
      rst_n  = 1'b1;
      enable = 1'b1;

      // First spawn on the 45th tick
      repeat (44) frame();
      check("pre_spawn_idle", 32'(active), 32'(0));
      lane_a = lane_of(exp_lfsr);
      tick_rise();
      check("grant_not_early", 32'(active), 32'(0));
      tick_edge();
      check("first_grant", 32'(active), 32'(lane_mask(lane_a)));
      frame_end();

      // Catch in the window
      in_position = lane_mask(lane_a);
      frame();
      check("window_active", 32'(active), 32'(lane_mask(lane_a)));
      hit_pulse(lane_mask(lane_a));
      check("catch_active_low", 32'(active), 32'(0));
      check("catch_pulse", 32'(catch_pulse), 32'(1));
      check("catch_score", 32'(score), 32'(1));
      @(negedge clk);
      check("catch_pulse_1cyc", 32'(catch_pulse), 32'(0));
      in_position = '0;

      // Second coin: hit in travel is ignored, then window expires
      while (tick_no < 89) frame();
      check("cooldown_inactive", 32'(active), 32'(0));
      lane_b = lane_of(exp_lfsr);
      frame();
      check("second_grant", 32'(active), 32'(lane_mask(lane_b)));
      hit_pulse(lane_mask(lane_b));
      check("travel_hit_score", 32'(score), 32'(1));
      check("travel_hit_pulse", 32'(catch_pulse), 32'(0));
      check("travel_hit_active", 32'(active), 32'(lane_mask(lane_b)));
      in_position = lane_mask(lane_b);
      frame();
      in_position = '0;
      repeat (11) frame();
      check("window_11_active", 32'(active), 32'(lane_mask(lane_b)));
      check("window_11_misses", 32'(misses), 32'(0));
      tick_rise();
      tick_edge();
      check("miss_pulse", 32'(miss_pulse), 32'(1));
      check("miss_count", 32'(misses), 32'(1));
      check("miss_active_low", 32'(active), 32'(0));
      frame_end();
      check("miss_pulse_1cyc", 32'(miss_pulse), 32'(0));

      // 200 frames with no coin reaching position: live cap of two
      over_cap = 0;
      c1 = 0;
      c2 = 0;
      while (tick_no < 303) begin
         if (tick_no == 134) c1 = lane_of(exp_lfsr);
         if (tick_no == 179) begin
            p  = lane_of(exp_lfsr);
            c2 = (p == c1) ? (p + 1) % N : p;
         end
         frame();
         if ($countones(active) > 2) over_cap++;
      end
      check("live_cap", 32'(over_cap), 32'(0));
      check("two_live", 32'(active), 32'(lane_mask(c1) | lane_mask(c2)));
      l3 = 3 - c1 - c2;

      // Free one slot: the held request must grant on the very next tick
      in_position = lane_mask(c1);
      frame();
      hit_pulse(lane_mask(c1));
      check("cap_catch_score", 32'(score), 32'(2));
      check("cap_catch_active", 32'(active), 32'(lane_mask(c2)));
      in_position = '0;
      frame();
      check("pending_retry", 32'(active), 32'(lane_mask(c2) | lane_mask(l3)));

      // Two simultaneous misses, then run on to game over
      in_position = '1;
      frame();
      repeat (11) frame();
      tick_rise();
      tick_edge();
      check("double_miss_pulse", 32'(miss_pulse), 32'(1));
      check("double_miss_count", 32'(misses), 32'(3));
      frame_end();
      for (int i = 0; i < 120 && misses != 8'd5; i++) frame();
      check("misses_five", 32'(misses), 32'(5));
      check("game_over_set", 32'(game_over), 32'(1));
      seen = '0;
      repeat (100) begin
         frame();
         seen = seen | active;
      end
      check("no_grant_after_over", 32'(seen), 32'(0));
      check("misses_stuck", 32'(misses), 32'(5));
      check("game_over_held", 32'(game_over), 32'(1));

      // Reset clears game over
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      in_position = '0;
      exp_lfsr = 8'hA5;
      tick_no = 0;
      @(negedge clk);
      check("reset_game_over", 32'(game_over), 32'(0));
      check("reset_misses", 32'(misses), 32'(0));

      // Disable aborts a coin in its window with no score or miss
      wait_grant(m);
      in_position = m;
      frame();
      in_position = '0;
      check("abort_pre_active", 32'(active), 32'(m));
      enable = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      check("abort_active_low", 32'(active), 32'(0));
      check("abort_score", 32'(score), 32'(0));
      check("abort_misses", 32'(misses), 32'(0));
      check("abort_pulses", 32'({catch_pulse, miss_pulse}), 32'(0));

      // Seven catches, then an eighth coin left in its window
      for (int k = 1; k <= 7; k++) begin
         wait_grant(m);
         in_position = m;
         frame();
         in_position = '0;
         hit_pulse(m);
         check("score_step", 32'(score), 32'(k));
      end
      wait_grant(m);
      in_position = m;
      frame();
      in_position = '0;
      check("mid_window_active", 32'(active), 32'(m));

      // Asynchronous reset between clock edges
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_active", 32'(active), 32'(0));
      check("async_rst_score", 32'(score), 32'(0));
      check("async_rst_misses", 32'(misses), 32'(0));
      check("async_rst_pulses", 32'({catch_pulse, miss_pulse, game_over}), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
